// File: rtl/hk_spi_bus_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : hk_spi_bus_bridge_if
// Brief    : Single-beat Wishbone-style bus between the housekeeping SPI
//            bridge (master) and the housekeeping register bank (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface hk_spi_bus_bridge_if;
  logic       bus_cyc;
  logic       bus_stb;
  logic       bus_we;
  logic [7:0] bus_adr;
  logic [7:0] bus_dat_o;
  logic [7:0] bus_dat_i;
  logic       bus_ack;

  modport master (
    output bus_cyc, bus_stb, bus_we, bus_adr, bus_dat_o,
    input  bus_dat_i, bus_ack
  );

  modport slave (
    input  bus_cyc, bus_stb, bus_we, bus_adr, bus_dat_o,
    output bus_dat_i, bus_ack
  );
endinterface
`default_nettype wire

// File: rtl/hk_spi_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : hk_spi_bus_bridge
// Brief    : Moves housekeeping SPI register accesses (SCK domain) into the
//            system clock domain via toggle handshakes, runs one bus access
//            per request and returns read data to the SPI shifter.
// Revision : 1.0 - initial release
// ============================================================================
module hk_spi_bus_bridge #(
  parameter int unsigned TIMEOUT         = 255,
  parameter logic [7:0]  RD_TIMEOUT_DATA = 8'h00
) (
  input  wire                  clk,
  input  wire                  csb_reset,
  input  wire                  sck,
  input  wire  [7:0]           spi_addr,
  input  wire  [7:0]           spi_wdata,
  input  wire                  spi_wrstb,
  input  wire                  spi_rdreq,
  output logic [7:0]           spi_idata,
  output logic                 spi_rdvalid,
  output logic                 overrun,
  hk_spi_bus_bridge_if.master  bus,
  output logic                 timeout_err
);

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  // ---------------------------------------------------------------- SCK side
  logic       req_tog;
  logic       ack_s1;
  logic       ack_s2;
  logic [7:0] hold_adr;
  logic [7:0] hold_dat;
  logic       hold_we;
  logic       pending;
  logic       ack_arrive;

  // clk-side signals referenced across domains
  logic       ack_tog;
  logic [7:0] rdata_clk;

  assign pending    = (req_tog != ack_s2);
  // The synchronized ack toggle is about to change on this sck edge.
  assign ack_arrive = (ack_s1 != ack_s2);

  // Bring the clk-side acknowledge toggle into the sck domain.
  always_ff @(posedge sck or posedge csb_reset) begin
    if (csb_reset) begin
      ack_s1 <= 1'b0;
      ack_s2 <= 1'b0;
    end else begin
      ack_s1 <= ack_tog;
      ack_s2 <= ack_s1;
    end
  end

  // Capture strobes into the hold registers and load returned read data.
  always_ff @(posedge sck or posedge csb_reset) begin
    if (csb_reset) begin
      req_tog     <= 1'b0;
      hold_adr    <= 8'h00;
      hold_dat    <= 8'h00;
      hold_we     <= 1'b0;
      spi_idata   <= 8'h00;
      spi_rdvalid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      // rdata_clk has been stable since the clk side left BUS.
      if (ack_arrive && !hold_we) begin
        spi_idata   <= rdata_clk;
        spi_rdvalid <= 1'b1;
      end
      if (spi_wrstb) begin
        if (pending) begin
          overrun <= 1'b1;
        end else begin
          hold_adr <= spi_addr;
          hold_dat <= spi_wdata;
          hold_we  <= 1'b1;
          req_tog  <= ~req_tog;
        end
        // A read colliding with a write is always lost.
        if (spi_rdreq) overrun <= 1'b1;
      end else if (spi_rdreq) begin
        if (pending) begin
          overrun <= 1'b1;
        end else begin
          hold_adr    <= spi_addr;
          hold_we     <= 1'b0;
          req_tog     <= ~req_tog;
          spi_rdvalid <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------- clk side
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  logic [1:0] rst_pipe;
  logic       rst_clk;
  logic       req_s1;
  logic       req_s2;
  logic       seen;
  state_t     state;
  logic [7:0] tcnt;
  logic [7:0] tcnt_next;
  logic       cyc;
  logic       we;
  logic [7:0] adr;
  logic [7:0] dat_o;

  assign rst_clk   = rst_pipe[1];
  assign tcnt_next = tcnt + 8'd1;

  assign bus.bus_cyc   = cyc;
  assign bus.bus_stb   = cyc;
  assign bus.bus_we    = we;
  assign bus.bus_adr   = adr;
  assign bus.bus_dat_o = dat_o;

  // Reset asserts immediately, releases two clk edges later.
  always_ff @(posedge clk or posedge csb_reset) begin
    if (csb_reset) rst_pipe <= 2'b11;
    else           rst_pipe <= {rst_pipe[0], 1'b0};
  end

  // Request synchronizer plus single-beat bus access state machine.
  always_ff @(posedge clk or posedge rst_clk) begin
    if (rst_clk) begin
      req_s1      <= 1'b0;
      req_s2      <= 1'b0;
      seen        <= 1'b0;
      ack_tog     <= 1'b0;
      state       <= S_IDLE;
      tcnt        <= 8'h00;
      rdata_clk   <= 8'h00;
      cyc         <= 1'b0;
      we          <= 1'b0;
      adr         <= 8'h00;
      dat_o       <= 8'h00;
      timeout_err <= 1'b0;
    end else begin
      req_s1 <= req_tog;
      req_s2 <= req_s1;
      case (state)
        S_IDLE: begin
          // Hold registers are quasi-static while a request is pending.
          if (req_s2 != seen) begin
            adr   <= hold_adr;
            dat_o <= hold_dat;
            we    <= hold_we;
            cyc   <= 1'b1;
            tcnt  <= 8'h00;
            state <= S_BUS;
          end
        end
        S_BUS: begin
          tcnt <= tcnt_next;
          if (bus.bus_ack) begin
            if (!we) rdata_clk <= bus.bus_dat_i;
            cyc   <= 1'b0;
            state <= S_DONE;
          end else if (tcnt_next == TO_LIMIT) begin
            timeout_err <= 1'b1;
            if (!we) rdata_clk <= RD_TIMEOUT_DATA;
            cyc   <= 1'b0;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          seen    <= req_s2;
          ack_tog <= ~ack_tog;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hk_spi_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_hk_spi_bus_bridge
// Brief    : Directed, table-driven bench for hk_spi_bus_bridge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hk_spi_bus_bridge;

  logic       clk = 1'b0;
  logic       sck = 1'b0;
  logic       csb_reset = 1'b1;
  logic [7:0] spi_addr = 8'h00;
  logic [7:0] spi_wdata = 8'h00;
  logic       spi_wrstb = 1'b0;
  logic       spi_rdreq = 1'b0;
  logic [7:0] spi_idata;
  logic       spi_rdvalid;
  logic       overrun;
  logic       timeout_err;

  hk_spi_bus_bridge_if bus_if ();

  hk_spi_bus_bridge #(
    .TIMEOUT         (16),
    .RD_TIMEOUT_DATA (8'h00)
  ) dut (
    .clk         (clk),
    .csb_reset   (csb_reset),
    .sck         (sck),
    .spi_addr    (spi_addr),
    .spi_wdata   (spi_wdata),
    .spi_wrstb   (spi_wrstb),
    .spi_rdreq   (spi_rdreq),
    .spi_idata   (spi_idata),
    .spi_rdvalid (spi_rdvalid),
    .overrun     (overrun),
    .bus         (bus_if),
    .timeout_err (timeout_err)
  );

  // clk runs 4x sck
  always #5  clk = ~clk;
  always #20 sck = ~sck;

  // Bus slave model: ack after ack_delay wait cycles, or never when disabled.
  int         ack_delay = 0;
  bit         ack_en    = 1'b1;
  bit         ack_force = 1'b0;
  logic [7:0] rd_data   = 8'h00;
  int         wait_cnt  = 0;

  always @(negedge clk) begin
    if (ack_force) begin
      bus_if.bus_ack = 1'b1;
    end else if (ack_en && bus_if.bus_cyc) begin
      bus_if.bus_ack = (wait_cnt == ack_delay);
      wait_cnt++;
    end else begin
      bus_if.bus_ack = 1'b0;
      wait_cnt = 0;
    end
    bus_if.bus_dat_i = rd_data;
  end

  // Bus monitor: counts cycles, records the access, measures cyc length.
  int         n_cyc   = 0;
  int         cyc_len = 0;
  int         stb_err = 0;
  logic       cyc_q   = 1'b0;
  logic [7:0] last_adr = 8'h00;
  logic [7:0] last_dat = 8'h00;
  logic       last_we  = 1'b0;

  always @(negedge clk) begin
    if (bus_if.bus_stb !== bus_if.bus_cyc) stb_err++;
    if (bus_if.bus_cyc === 1'b1 && !cyc_q) begin
      n_cyc++;
      cyc_len  = 1;
      last_adr = bus_if.bus_adr;
      last_dat = bus_if.bus_dat_o;
      last_we  = bus_if.bus_we;
    end else if (bus_if.bus_cyc === 1'b1) begin
      cyc_len++;
    end
    cyc_q = (bus_if.bus_cyc === 1'b1);
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_sck(input int n);
    repeat (n) @(negedge sck);
  endtask

  task automatic do_reset();
    csb_reset = 1'b1;
    wait_sck(2);
    csb_reset = 1'b0;
    wait_sck(2);
  endtask

  task automatic spi_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge sck);
    spi_addr = a; spi_wdata = d; spi_wrstb = 1'b1;
    @(negedge sck);
    spi_wrstb = 1'b0;
  endtask

  task automatic spi_read(input logic [7:0] a);
    @(negedge sck);
    spi_addr = a; spi_rdreq = 1'b1;
    @(negedge sck);
    spi_rdreq = 1'b0;
  endtask

  task automatic wait_rdvalid(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (spi_rdvalid === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge sck);
    end
    check({name, "_rdvalid_arrives"}, got, 1);
  endtask

  typedef struct {
    bit         we;
    logic [7:0] adr;
    logic [7:0] wdata;
    logic [7:0] rdat;
    int         dly;
    logic [7:0] exp_idata;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int n0;

    vecs[0] = '{we: 1'b1, adr: 8'h0A, wdata: 8'h5C, rdat: 8'h00, dly: 2, exp_idata: 8'h00};
    vecs[1] = '{we: 1'b0, adr: 8'h03, wdata: 8'h00, rdat: 8'hA7, dly: 1, exp_idata: 8'hA7};
    vecs[2] = '{we: 1'b1, adr: 8'h7F, wdata: 8'hFF, rdat: 8'h00, dly: 0, exp_idata: 8'h00};
    vecs[3] = '{we: 1'b0, adr: 8'hFF, wdata: 8'h00, rdat: 8'h3C, dly: 0, exp_idata: 8'h3C};
    vecs[4] = '{we: 1'b1, adr: 8'h00, wdata: 8'h81, rdat: 8'h00, dly: 5, exp_idata: 8'h00};

    // Reset state
    wait_sck(3);
    csb_reset = 1'b0;
    wait_sck(2);
    check("rst_idata",   spi_idata, 8'h00);
    check("rst_rdvalid", spi_rdvalid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_cyc",     bus_if.bus_cyc, 0);
    check("rst_stb",     bus_if.bus_stb, 0);
    check("rst_we",      bus_if.bus_we, 0);
    check("rst_adr",     bus_if.bus_adr, 8'h00);
    check("rst_dat_o",   bus_if.bus_dat_o, 8'h00);
    check("rst_tmo",     timeout_err, 0);

    // Table of single accesses
    for (int k = 0; k < 5; k++) begin
      ack_delay = vecs[k].dly;
      rd_data   = vecs[k].rdat;
      n0        = n_cyc;
      if (vecs[k].we) begin
        spi_write(vecs[k].adr, vecs[k].wdata);
        wait_sck(10);
        check($sformatf("v%0d_dat_o", k), last_dat, vecs[k].wdata);
      end else begin
        spi_read(vecs[k].adr);
        check($sformatf("v%0d_rdvalid_clr", k), spi_rdvalid, 0);
        wait_rdvalid($sformatf("v%0d", k));
        check($sformatf("v%0d_idata", k), spi_idata, vecs[k].exp_idata);
        wait_sck(2);
      end
      check($sformatf("v%0d_ncyc", k), n_cyc - n0, 1);
      check($sformatf("v%0d_we", k),   last_we, vecs[k].we);
      check($sformatf("v%0d_adr", k),  last_adr, vecs[k].adr);
      check($sformatf("v%0d_ovr", k),  overrun, 0);
      check($sformatf("v%0d_tmo", k),  timeout_err, 0);
    end

    // Ack coincident with the timeout count: ack wins
    ack_delay = 15;
    n0 = n_cyc;
    spi_write(8'h31, 8'h42);
    wait_sck(12);
    check("coinc_w_ncyc", n_cyc - n0, 1);
    check("coinc_w_len",  cyc_len, 16);
    check("coinc_w_tmo",  timeout_err, 0);
    rd_data = 8'hC3;
    spi_read(8'h32);
    wait_rdvalid("coinc_r");
    check("coinc_r_idata", spi_idata, 8'hC3);
    check("coinc_r_tmo",   timeout_err, 0);
    wait_sck(2);

    // Read timeout with no ack at all
    ack_en  = 1'b0;
    rd_data = 8'h77;
    n0 = n_cyc;
    spi_read(8'h20);
    wait_rdvalid("tmo");
    check("tmo_idata", spi_idata, 8'h00);
    check("tmo_err",   timeout_err, 1);
    check("tmo_len",   cyc_len, 16);
    check("tmo_adr",   last_adr, 8'h20);
    check("tmo_ncyc",  n_cyc - n0, 1);
    wait_sck(2);
    ack_en    = 1'b1;
    ack_delay = 0;
    rd_data   = 8'h99;
    spi_read(8'h21);
    wait_rdvalid("post_tmo");
    check("post_tmo_idata", spi_idata, 8'h99);
    check("post_tmo_err",   timeout_err, 1);
    wait_sck(2);

    // Overrun: back-to-back write strobes
    do_reset();
    check("ovr_rst_tmo", timeout_err, 0);
    ack_delay = 2;
    n0 = n_cyc;
    @(negedge sck);
    spi_addr = 8'h0A; spi_wdata = 8'h11; spi_wrstb = 1'b1;
    @(negedge sck);
    spi_addr = 8'h0B; spi_wdata = 8'h22;
    @(negedge sck);
    spi_wrstb = 1'b0;
    wait_sck(10);
    check("ovr_ncyc", n_cyc - n0, 1);
    check("ovr_adr",  last_adr, 8'h0A);
    check("ovr_dat",  last_dat, 8'h11);
    check("ovr_flag", overrun, 1);
    spi_write(8'h0C, 8'h33);
    wait_sck(10);
    check("ovr_next_adr", last_adr, 8'h0C);
    check("ovr_sticky",   overrun, 1);

    // Simultaneous write and read strobes
    do_reset();
    check("sim_rst_ovr", overrun, 0);
    n0 = n_cyc;
    @(negedge sck);
    spi_addr = 8'h44; spi_wdata = 8'h12; spi_wrstb = 1'b1; spi_rdreq = 1'b1;
    @(negedge sck);
    spi_wrstb = 1'b0; spi_rdreq = 1'b0;
    wait_sck(10);
    check("sim_ncyc", n_cyc - n0, 1);
    check("sim_we",   last_we, 1);
    check("sim_adr",  last_adr, 8'h44);
    check("sim_dat",  last_dat, 8'h12);
    check("sim_ovr",  overrun, 1);

    // Reset in the middle of a bus cycle
    do_reset();
    ack_en = 1'b0;
    n0 = n_cyc;
    spi_write(8'h55, 8'hAA);
    for (int i = 0; i < 200 && bus_if.bus_cyc !== 1'b1; i++) @(negedge clk);
    check("mid_cyc_seen", bus_if.bus_cyc, 1);
    #2;
    csb_reset = 1'b1;
    #1;
    check("mid_cyc",   bus_if.bus_cyc, 0);
    check("mid_stb",   bus_if.bus_stb, 0);
    check("mid_we",    bus_if.bus_we, 0);
    check("mid_adr",   bus_if.bus_adr, 8'h00);
    check("mid_dat_o", bus_if.bus_dat_o, 8'h00);
    check("mid_ovr",   overrun, 0);
    check("mid_tmo",   timeout_err, 0);
    check("mid_rdv",   spi_rdvalid, 0);
    wait_sck(2);
    csb_reset = 1'b0;
    ack_force = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ack_force = 1'b0;
    ack_en    = 1'b1;
    wait_sck(10);
    check("late_ack_ncyc", n_cyc - n0, 1);
    check("late_ack_tmo",  timeout_err, 0);
    check("late_ack_cyc",  bus_if.bus_cyc, 0);
    ack_delay = 1;
    spi_write(8'h66, 8'hAB);
    wait_sck(10);
    check("post_rst_ncyc", n_cyc - n0, 2);
    check("post_rst_adr",  last_adr, 8'h66);
    check("post_rst_dat",  last_dat, 8'hAB);
    check("post_rst_we",   last_we, 1);
    check("post_rst_ovr",  overrun, 0);

    check("stb_eq_cyc", stb_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hk_spi_bus_bridge.md
Name: hk_spi_bus_bridge

Overview:
- Sits directly downstream of the housekeeping SPI slave.
- Captures its SCK-domain write and read strobes, address and data, and moves each access into the system clock domain via toggle handshakes.
- Runs a single-beat Wishbone-style access to the housekeeping register bank.
- Returns read data to the SPI side as an 8-bit holding register that feeds the SPI `idata` shifter.

Parameters:
TIMEOUT, 255, clk cycles to wait for bus_ack before abandoning an access (8-bit counter; range 1..255)
RD_TIMEOUT_DATA, 8'h00, value returned on spi_idata when a read times out

Ports:
clk  in  1  system clock (bus side); must run ≥4× SCK
csb_reset  in  1  reset, asynchronous, active-high (CSB | reset); resets both domains
sck  in  1  SPI clock (SPI side)
spi_addr  in  8  register address, valid when a strobe is sampled
spi_wdata  in  8  write data, valid with spi_wrstb
spi_wrstb  in  1  write request, sampled on posedge sck
spi_rdreq  in  1  read request, single sck-cycle pulse, sampled on posedge sck
spi_idata  out  8  read data holding register (sck domain)
spi_rdvalid  out  1  spi_idata updated since last spi_rdreq (sck domain)
overrun  out  1  sticky: a request was dropped because one was still pending (sck domain)
bus_cyc  out  1  bus cycle active
bus_stb  out  1  strobe; equals bus_cyc
bus_we  out  1  1 = write
bus_adr  out  8  bus address
bus_dat_o  out  8  bus write data
bus_dat_i  in  8  bus read data
bus_ack  in  1  bus acknowledge, single clk cycle
timeout_err  out  1  sticky: an access timed out (clk domain)

Behaviour:

Reset:
- csb_reset asserts asynchronously in both domains.
- clk domain deasserts through an internal 2-flop synchronizer.
- Reset values: spi_idata=8'h00, spi_rdvalid=0, overrun=0, bus_cyc=bus_stb=bus_we=0, bus_adr=8'h00, bus_dat_o=8'h00, timeout_err=0.
- All toggles and pending flags reset to 0.

SCK-side request capture (posedge sck):
- pending = (req_tog != ack_tog_sync), where ack_tog_sync is ack_tog passed through 2 sck flops.
- If spi_wrstb=1 and !pending: latch addr/data into hold regs, set hold_we=1, flip req_tog.
- Else if spi_rdreq=1 and !pending: latch addr, set hold_we=0, flip req_tog, clear spi_rdvalid.
- If spi_wrstb and spi_rdreq are both 1 in the same cycle, the write wins and the read is dropped; overrun is set.
- Any strobe arriving while pending is dropped and sets overrun.
- Hold regs are stable from the toggle flip until the ack returns.

clk-side FSM (req_tog passes through 2 clk flops to req_sync; seen = last serviced value):
- IDLE:
  - req_sync != seen: copy hold regs into bus_adr/bus_dat_o/bus_we, assert bus_cyc/bus_stb, clear tcnt → BUS.
  - The hold regs are quasi-static, so sampling them here is safe.
- BUS:
  - tcnt increments each clk.
  - bus_ack=1: for a read, capture bus_dat_i into rdata_clk; drop cyc/stb → DONE.
  - tcnt==TIMEOUT with no ack: set timeout_err; for a read, rdata_clk=RD_TIMEOUT_DATA; drop cyc/stb → DONE.
  - An ack arriving in the same cycle as the timeout wins; no error is raised.
- DONE: seen<=req_sync, flip ack_tog → IDLE (one clk).
- Exactly one bus access per request; cyc is high for at least 1 clk.

Read return:
- SCK side: when ack_tog_sync changes and the last request was a read, load spi_idata from rdata_clk (stable since DONE) and set spi_rdvalid=1.

Latency, write:
- sck→clk sync 2–3 clk, +1 clk IDLE, + ack wait.
- With zero-wait ack (ack on first BUS cycle): cyc asserted 3–4 clk after the req_tog flip.

Latency, read:
- Above, plus 2 sck edges to return.
- The upstream SPI must issue spi_rdreq at least 3 sck cycles before it loads spi_idata.

csb_reset mid-access:
- bus_cyc/bus_stb drop asynchronously.
- An ack arriving after reset is ignored.
- No partial write is reissued after reset.

Test Plan:
- Write: spi_wrstb with addr=8'h0A, wdata=8'h5C, clk=4×sck, ack after 2 clk → exactly one bus cycle with we=1, adr=0A, dat_o=5C; pending clears; overrun=0.
- Read: spi_rdreq with addr=8'h03, bus_dat_i=8'hA7 acked after 1 clk → spi_idata=A7 and spi_rdvalid=1 within TIMEOUT-independent latency; spi_rdvalid=0 in the sck cycle after the request.
- Timeout: TIMEOUT=16, read of addr=8'h20, bus_ack never asserted → cyc drops after 16 clk; timeout_err=1; spi_idata=8'h00; next access proceeds normally.
- Overrun: second spi_wrstb (addr=0B) one sck after first (addr=0A) → only the 0A bus write occurs; overrun=1 (sticky until csb_reset).
- Simultaneous spi_wrstb and spi_rdreq → write performed, read dropped, overrun=1; ack coincident with timeout count → no timeout_err.
- csb_reset pulse while bus_cyc=1 → cyc/stb/we=0 immediately; all outputs at reset values; late bus_ack produces no state change; fresh write after reset completes normally.
